// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug variable controller.
// Digit count, power-on value and FSM states live here so every file agrees.
package debug_pkg;

    localparam int NIB = 16;
    localparam logic [63:0] INIT_VAL_DEFAULT = 64'h0000_0000_0000_1234;

    typedef enum logic {
        ACTIVE = 1'b0,
        COMMIT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb16.sv
// Combinational 16-way round-robin picker: grants the lowest requesting
// index at or above the pointer, wrapping from 15 back to 0.
module rr_arb16 (
    input  logic [15:0] req_i,
    input  logic [3:0]  ptr_i,
    output logic        gnt_valid_o,
    output logic [3:0]  gnt_idx_o
);

    logic [3:0] cand;

    // Scan offsets from the far end down so the smallest offset from ptr_i wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = ptr_i;
        cand        = '0;
        for (int k = 15; k >= 0; k--) begin
            cand = ptr_i + 4'(k);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/debug_var_ctrl.sv
// Button/host-driven 64-bit debug register whose value only changes during
// vertical blanking; one digit increment or host write is committed per cycle.
module debug_var_ctrl #(
    parameter logic [63:0] INIT_VAL = debug_pkg::INIT_VAL_DEFAULT,
    parameter int          NIB      = debug_pkg::NIB
) (
    input  logic           vga_clk,
    input  logic           vga_rst,
    input  logic [NIB-1:0] btns,
    input  logic           vblank,
    input  logic           wr_req,
    input  logic [63:0]    wr_data,
    output logic           wr_ack,
    output logic [63:0]    var_out,
    output logic [NIB-1:0] pending,
    output logic           upd_valid,
    output logic [3:0]     upd_idx
);

    import debug_pkg::*;

    state_e         state_q, state_d;
    logic [NIB-1:0] btn_q;
    logic [NIB-1:0] pending_q, pending_d;
    logic [NIB-1:0] btnEdge, clrMask;
    logic [63:0]    var_q, var_d;
    logic [3:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]     upd_idx_q, upd_idx_d;
    logic           wr_ack_q, wr_ack_d;
    logic           upd_valid_q, upd_valid_d;
    logic           gntValid;
    logic [3:0]     gntIdx;
    logic           commitEn, hostWr, btnCommit;

    assign btnEdge = btns & ~btn_q;

    rr_arb16 uArb (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gntValid),
        .gnt_idx_o   (gntIdx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:  if (vblank)  state_d = COMMIT;
            COMMIT:  if (!vblank) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    // Gating on vblank as well keeps var_out frozen on the exit cycle of COMMIT.
    // The ack cycle itself is never a write, so a held wr_req re-arms one cycle later.
    always_comb begin
        commitEn    = (state_q == COMMIT) && vblank;
        hostWr      = commitEn && wr_req && !wr_ack_q;
        btnCommit   = commitEn && !hostWr && gntValid;
        var_d       = var_q;
        rr_ptr_d    = rr_ptr_q;
        upd_idx_d   = upd_idx_q;
        wr_ack_d    = 1'b0;
        upd_valid_d = 1'b0;
        clrMask     = '0;
        if (hostWr) begin
            var_d    = wr_data;
            wr_ack_d = 1'b1;
        end else if (btnCommit) begin
            var_d[{gntIdx, 2'b00} +: 4] = var_q[{gntIdx, 2'b00} +: 4] + 4'd1;
            clrMask[gntIdx] = 1'b1;
            rr_ptr_d        = gntIdx + 4'd1;
            upd_valid_d     = 1'b1;
            upd_idx_d       = gntIdx;
        end
        pending_d = (pending_q & ~clrMask) | btnEdge;
    end

    // btn_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            state_q     <= ACTIVE;
            btn_q       <= '1;
            pending_q   <= '0;
            var_q       <= INIT_VAL;
            rr_ptr_q    <= '0;
            upd_idx_q   <= '0;
            wr_ack_q    <= 1'b0;
            upd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btns;
            pending_q   <= pending_d;
            var_q       <= var_d;
            rr_ptr_q    <= rr_ptr_d;
            upd_idx_q   <= upd_idx_d;
            wr_ack_q    <= wr_ack_d;
            upd_valid_q <= upd_valid_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign var_out   = var_q;
    assign pending   = pending_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;

endmodule

// File: doc/debug_var_ctrl.md
DEBUG_VAR_CTRL -- requirements
Module: debug_var_ctrl

Interface
REQ-001 SHALL have parameter INIT_VAL, default 64'h0000_0000_0000_1234, value loaded into var_out on reset.
REQ-002 SHALL have parameter NIB, default 16, number of 4-bit digits and button requesters.
REQ-003 SHALL have port vga_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port vga_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btns  input  16  button levels, already synchronous to vga_clk; bit i requests increment of digit i.
REQ-006 SHALL have port vblank  input  1  high during vertical blanking; the only window in which var_out may change.
REQ-007 SHALL have port wr_req  input  1  host full-word write request, held until acknowledged.
REQ-008 SHALL have port wr_data  input  64  host write value, stable while wr_req=1.
REQ-009 SHALL have port wr_ack  output  1  one-cycle pulse, registered; marks the cycle var_out takes wr_data.
REQ-010 SHALL have port var_out  output  64  registered debug value; digit i is var_out[4i+3:4i].
REQ-011 SHALL have port pending  output  16  registered sticky per-digit request flags.
REQ-012 SHALL have port upd_valid  output  1  one-cycle pulse, registered; a button update was committed.
REQ-013 SHALL have port upd_idx  output  4  index of the digit committed with upd_valid; holds its last value otherwise.

Function
REQ-014 SHALL register btns into btn_q each cycle; edge[i] = btns[i] & ~btn_q[i].
REQ-015 SHALL set pending[i] the cycle after edge[i]=1; an edge while pending[i]=1 is absorbed (no double count).
REQ-016 SHALL treat simultaneous edges on several bits independently; all corresponding flags set.
REQ-017 SHALL implement FSM {ACTIVE, COMMIT}; ACTIVE->COMMIT when vblank=1; COMMIT->ACTIVE when vblank=0; no other transitions.
REQ-018 SHALL commit at most one update per cycle, and only in state COMMIT.
REQ-019 SHALL give the host absolute priority: in COMMIT with wr_req=1, var_out<=wr_data and wr_ack=1 next cycle; no button commit that cycle.
REQ-020 SHALL deassert wr_ack the cycle after a pulse even if wr_req remains high; a still-high wr_req is a new request.
REQ-021 SHALL otherwise pick, round-robin, the lowest pending index at or above pointer rr_ptr, wrapping 15->0.
REQ-022 SHALL on commit of digit i: digit i <= digit i + 1 modulo 16 (F->0, no carry to digit i+1); clear pending[i]; rr_ptr <= (i+1) mod 16; upd_valid=1, upd_idx=i.
REQ-023 SHALL let set win over clear when a new edge on digit i coincides with its commit; pending[i] stays 1.
REQ-024 SHALL keep pending bits and rr_ptr unchanged by host writes.
REQ-025 SHALL hold var_out, pending and rr_ptr unchanged in ACTIVE except for flag setting per REQ-015.
REQ-026 SHALL have latency: edge sampled cycle t -> pending cycle t+1 -> earliest commit visible on var_out cycle t+2 when FSM is in COMMIT.
REQ-027 SHALL stop committing the first cycle FSM returns to ACTIVE; unserviced flags carry to the next blanking.

Reset
REQ-028 SHALL on vga_rst: var_out=INIT_VAL, pending=0, rr_ptr=0, FSM=ACTIVE, wr_ack=0, upd_valid=0, upd_idx=0.
REQ-029 SHALL reset btn_q to 16'hFFFF so buttons held through reset produce no edge.
REQ-030 SHALL abandon any in-flight host request on reset mid-operation; host must reissue; no wr_ack for it.

Structure
REQ-031 SHALL place NIB, INIT_VAL default and the FSM state encoding in shared package debug_pkg.
REQ-032 SHALL implement round-robin selection in sub-module rr_arb16 (16-bit request, 4-bit pointer in; grant valid plus 4-bit index out; combinational).

Verification
REQ-033 SHALL cover: reset, pulse btns[0] one cycle, vblank=1 -> pending=0x0001 then var_out=0x...1235, upd_idx=0.
REQ-034 SHALL cover: digit 3 =F, edge on btns[3] in blanking -> digit 3 =0, digit 4 unchanged.
REQ-035 SHALL cover: edges on bits 2,5,9 same cycle, vblank=1 -> commits in order 2,5,9 on consecutive cycles, rr_ptr=10.
REQ-036 SHALL cover: wr_req=1, wr_data=64'hDEAD_BEEF_0000_0000 with pending=0x0002 in blanking -> wr_ack first cycle, var_out=DEAD_BEEF_0000_0000, then digit 1 commit ->...0010.
REQ-037 SHALL cover: vblank=0 with pending=0x8001 -> var_out unchanged; next vblank commits 0 then 15.
REQ-038 SHALL cover: btns[7] held through vga_rst release -> pending stays 0; vga_rst asserted mid-blanking with wr_req=1 -> all outputs at reset values, no wr_ack.
